// File: rtl/rr_priority_encoder_if.sv
// Handshake bundle between request sources, the priority encoder and a binary-coded consumer.
// The slave modport is the encoder's view; the master modport is the view of whoever drives it.
interface rr_priority_encoder_if #(
    parameter int N     = 7,
    parameter int W     = $clog2(N + 1),
    parameter int CNT_W = 8
);
    logic             rr_en;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     req;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_code;
    logic [N-1:0]     out_onehot;
    logic             out_multi;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output rr_en, in_valid, req, out_ready,
        input  in_ready, out_valid, out_code, out_onehot, out_multi, err_cnt
    );

    modport slave (
        input  rr_en, in_valid, req, out_ready,
        output in_ready, out_valid, out_code, out_onehot, out_multi, err_cnt
    );
endinterface

// File: rtl/rr_priority_encoder.sv
// Registered N-line-to-binary encoder with fixed-priority and round-robin grant,
// multi-hot detection, a saturating multi-hot counter and a one-hot echo of the winner.
module rr_priority_encoder #(
    parameter int N     = 7,
    parameter int W     = $clog2(N + 1),
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    rr_priority_encoder_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    grant_idx;
    logic             grant_any;
    logic             multi_hot;
    logic             accept;

    logic             valid;
    logic [W-1:0]     code;
    logic [N-1:0]     onehot;
    logic             multi;
    logic [CNT_W-1:0] count;

    assign bus.in_ready   = !valid || bus.out_ready;
    assign accept         = bus.in_valid && bus.in_ready;

    assign bus.out_valid  = valid;
    assign bus.out_code   = code;
    assign bus.out_onehot = onehot;
    assign bus.out_multi  = multi;
    assign bus.err_cnt    = count;

    assign grant_any = |bus.req;
    // Clearing the lowest set bit leaves something behind only when two or more bits are set.
    assign multi_hot = |(bus.req & (bus.req - N'(1)));

    // Later loop iterations overwrite earlier ones, so each loop walks from lowest to highest priority.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_v;
        grant_idx = '0;
        idx       = 0;
        idx_v     = '0;
        if (!bus.rr_en) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req[PW'(i)]) begin
                    grant_idx = PW'(i);
                end
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                idx_v = PW'(idx);
                if (bus.req[idx_v]) begin
                    grant_idx = idx_v;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= 1'b0;
            code   <= '0;
            onehot <= '0;
            multi  <= 1'b0;
        end else if (accept) begin
            valid  <= 1'b1;
            code   <= grant_any ? (W'(grant_idx) + W'(1)) : '0;
            onehot <= grant_any ? (N'(1) << grant_idx) : '0;
            multi  <= multi_hot;
        end else if (bus.out_ready) begin
            valid  <= 1'b0;
        end
    end

    // The pointer tracks the last grant in both modes so a mode switch resumes from there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PW'(N - 1);
        end else if (accept && grant_any) begin
            ptr <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (accept && multi_hot && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench for rr_priority_encoder: directed vectors push expected results,
// a monitor pops and compares on every output transfer.
module tb_rr_priority_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rr_priority_encoder_if #(.N(7), .CNT_W(8)) ifc ();
    rr_priority_encoder_if #(.N(7), .CNT_W(2)) ifc2 ();

    rr_priority_encoder #(.N(7), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    rr_priority_encoder #(.N(7), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (ifc2.slave)
    );

    typedef struct packed {
        logic [2:0] code;
        logic       multi;
        logic [7:0] err;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Must be entered at a falling edge; returns at the falling edge after the accept.
    task automatic applyStimulus(input logic rr, input logic [6:0] r, input logic [2:0] code,
                                 input logic multi, input logic [7:0] err);
        int   waits;
        exp_t e;
        ifc.rr_en    = rr;
        ifc.in_valid = 1'b1;
        ifc.req      = r;
        #1;
        waits = 0;
        while (!ifc.in_ready && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        checkOutput("accept_ready", 32'(ifc.in_ready), 32'd1);
        if (ifc.in_ready) begin
            e.code  = code;
            e.multi = multi;
            e.err   = err;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        ifc.in_valid = 1'b0;
        ifc.req      = '0;
    endtask

    task automatic drain();
        idle();
        repeat (2) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    // Monitor samples just before each rising edge, when a transfer is about to happen.
    initial begin
        exp_t       e;
        logic [6:0] exp_oh;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && ifc.out_valid && ifc.out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 32'd0, 32'd1);
                end else begin
                    e      = sb.pop_front();
                    exp_oh = (e.code == 3'd0) ? 7'd0 : (7'd1 << (e.code - 3'd1));
                    checkOutput("out_code",   32'(ifc.out_code),   32'(e.code));
                    checkOutput("out_onehot", 32'(ifc.out_onehot), 32'(exp_oh));
                    checkOutput("out_multi",  32'(ifc.out_multi),  32'(e.multi));
                    checkOutput("err_cnt",    32'(ifc.err_cnt),    32'(e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ifc.rr_en     = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.req       = '0;
        ifc.out_ready = 1'b1;
        ifc2.rr_en    = 1'b0;
        ifc2.in_valid = 1'b0;
        ifc2.req      = '0;
        ifc2.out_ready = 1'b1;

        @(negedge clk);
        #1;
        checkOutput("rst_out_valid",  32'(ifc.out_valid),  32'd0);
        checkOutput("rst_out_code",   32'(ifc.out_code),   32'd0);
        checkOutput("rst_out_onehot", 32'(ifc.out_onehot), 32'd0);
        checkOutput("rst_err_cnt",    32'(ifc.err_cnt),    32'd0);
        checkOutput("rst_in_ready",   32'(ifc.in_ready),   32'd1);
        checkOutput("rst_err_cnt_sat", 32'(ifc2.err_cnt),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed priority, including an all-zero request.
        applyStimulus(1'b0, 7'b0000010, 3'd2, 1'b0, 8'd0);
        applyStimulus(1'b0, 7'b1010010, 3'd7, 1'b1, 8'd1);
        applyStimulus(1'b0, 7'b0000000, 3'd0, 1'b0, 8'd1);
        applyStimulus(1'b0, 7'b0011100, 3'd5, 1'b1, 8'd2);
        drain();

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Round-robin from reset with every line requesting.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 7'h7F, 3'((i % 7) + 1), 1'b1, 8'(i + 1));
        end
        idle();
        @(negedge clk);

        // Back-pressure: output must hold while a new request waits.
        ifc.out_ready = 1'b0;
        applyStimulus(1'b1, 7'b0000100, 3'd3, 1'b0, 8'd8);
        ifc.in_valid = 1'b1;
        ifc.req      = 7'b1000001;
        for (int i = 0; i < 3; i++) begin
            ifc.rr_en = i[0];
            #1;
            checkOutput("hold_in_ready", 32'(ifc.in_ready),   32'd0);
            checkOutput("hold_code",     32'(ifc.out_code),   32'd3);
            checkOutput("hold_onehot",   32'(ifc.out_onehot), 32'h04);
            @(negedge clk);
        end
        ifc.out_ready = 1'b1;
        applyStimulus(1'b1, 7'b1000001, 3'd7, 1'b1, 8'd9);
        applyStimulus(1'b0, 7'b0000011, 3'd2, 1'b1, 8'd10);
        applyStimulus(1'b1, 7'b0000011, 3'd1, 1'b1, 8'd11);
        drain();

        // Asynchronous reset while a result is held, then round-robin restarts at line 1.
        ifc.out_ready = 1'b0;
        applyStimulus(1'b1, 7'b0001000, 3'd4, 1'b0, 8'd11);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_out_valid",  32'(ifc.out_valid),  32'd0);
        checkOutput("async_out_code",   32'(ifc.out_code),   32'd0);
        checkOutput("async_out_onehot", 32'(ifc.out_onehot), 32'd0);
        checkOutput("async_err_cnt",    32'(ifc.err_cnt),    32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        ifc.out_ready = 1'b1;
        applyStimulus(1'b1, 7'h7F, 3'd1, 1'b1, 8'd1);
        drain();

        // Narrow counter must stick at its maximum.
        ifc2.rr_en    = 1'b0;
        ifc2.req      = 7'b0000011;
        ifc2.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sat_err_cnt_3", 32'(ifc2.err_cnt), 32'd3);
        repeat (2) @(posedge clk);
        #1;
        ifc2.in_valid = 1'b0;
        checkOutput("sat_err_cnt_5",  32'(ifc2.err_cnt),  32'd3);
        checkOutput("sat_out_multi",  32'(ifc2.out_multi), 32'd1);
        checkOutput("sat_out_code",   32'(ifc2.out_code),  32'd2);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
